cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
// - Multi-cycle control FSM for the 8-bit accumulator CPU (opcode[7:5], addr[4:0]).
// - Sequences the datapath: PC, instruction register, MemIns, MemData and accumulator.
// - Drives the control-signal bundle: pc_en, pc_load, jmp, halt, accumulator_control/_load, memIns_en, memDa_en, memDa_we.
// - Carries cycle and retired-instruction counters for CPI measurement.
// PARAMETERS
// - CNT_W   16  width of cycle_count / instr_count
// - ALUOP_W 3   width of accumulator_control (equals opcode width)
// PORTS
// - clk                  in   1        system clock, rising edge
// - rst                  in   1        asynchronous, active-high reset
// - opcode               in   3        IR[7:5]; HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
// - acc_zero             in   1        accumulator == 0
// - ir_load              out  1        latch MemIns output into IR
// - pc_en                out  1        PC <= PC+1
// - pc_load              out  1        PC <= IR[4:0]
// - jmp                  out  1        jump taken (qualifies pc_load)
// - halt                 out  1        CPU halted
// - memIns_en            out  1        instruction memory read enable
// - memDa_en             out  1        data memory enable
// - memDa_we             out  1        data memory write enable (only with memDa_en)
// - accumulator_load     out  1        accumulator captures ALU result
// - accumulator_control  out  ALUOP_W  ALU op (opcode of current instr)
// - cycle_count          out  CNT_W    cycles spent outside IDLE/HALTED
// - instr_count          out  CNT_W    retired instructions
// BEHAVIOUR
// - States: IDLE, FETCH, DECODE, EXEC, MEMRD, HALTED. Outputs are decoded from state/opcode/acc_zero; unlisted outputs are 0.
// - rst asserted, at any time including mid-instruction: state=IDLE, every output 0, counters 0.
// - IDLE: no outputs -> FETCH.
// - FETCH: memIns_en=1 (sync RAM, data next cycle) -> DECODE.
// - DECODE: ir_load=1, pc_en=1 -> EXEC. opcode is valid from EXEC onward.
// - EXEC:
//   - HLT: halt=1 -> HALTED.
//   - SKZ: pc_en=acc_zero -> FETCH.
//   - JMP: pc_load=1, jmp=1 -> FETCH.
//   - STO: memDa_en=1, memDa_we=1 -> FETCH.
//   - ADD/AND/XOR/LDA: memDa_en=1 -> MEMRD.
// - MEMRD: accumulator_load=1, accumulator_control=opcode -> FETCH.
// - HALTED: halt=1, held until rst; all other outputs 0.
// - Latency: HLT/SKZ/JMP/STO take 3 cycles (FETCH..EXEC); ADD/AND/XOR/LDA take 4.
// - acc_zero is sampled only in EXEC of SKZ. Its value in other states is don't-care.
// - cycle_count: +1 on every edge whose current state is FETCH/DECODE/EXEC/MEMRD.
// - instr_count: +1 on the edge leaving the last phase of an instruction (EXEC or MEMRD); HLT counts.
// - Both counters saturate at 2^CNT_W-1 and do not wrap.
// - memDa_we is never 1 without memDa_en. pc_en and pc_load are never 1 together.
// CONFIGURATION
// - CPU_SEQ_STEP_EN defined: adds ports step_mode (in,1) and step (in,1), plus state WAIT.
//   - With step_mode=1, every transition into FETCH (including from IDLE) goes to WAIT instead.
//   - WAIT: all outputs 0, counters hold; a step=1 sample moves WAIT -> FETCH.
//   - step_mode=0 gives WAIT -> FETCH on the next edge.
//   - step seen while not in WAIT is ignored.
// - CPU_SEQ_STEP_EN undefined: no step ports, no WAIT state, free-running as above.
// TESTING
// - Reset: rst=1 for 1 edge -> halt=0, all outputs 0, counters 0. After release, next edge enters FETCH (memIns_en=1).
// - HLT at mem[0]: halt=1 after the 3rd edge post-release and stays 1 for 10 more edges.
//   - Expect cycle_count=3, instr_count=1.
// - JMP 2 at mem[0], HLT at mem[2]: pc_load=jmp=1 in cycle 3 and halt=1 at cycle 6. mem[1] is never fetched; instr_count=2.
// - SKZ with acc_zero=1 in EXEC -> pc_en=1 in cycle 3. With acc_zero=0 -> pc_en=0.
// - LDA 5, STO 10, HLT: accumulator_load=1 with accumulator_control=5 in cycle 4, and memDa_en=memDa_we=1 in cycle 7.
//   - Halt at cycle 10; instr_count=3, cycle_count=10.
// - rst pulsed while in MEMRD -> outputs 0 immediately (async); restart from IDLE with counters 0.
// - CNT_W=4 with a JMP-to-self loop: cycle_count saturates at 15 and holds.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if
//
// Control bundle between the accumulator-CPU sequencer and its datapath.
//
// Parameters
//   CNT_W    width of the cycle / retired-instruction counters
//   ALUOP_W  width of the ALU operation select
//
// Signals
//   opcode               IR[7:5] of the instruction being executed
//   acc_zero             accumulator == 0
//   ir_load              latch instruction-memory output into IR
//   pc_en                PC <= PC + 1
//   pc_load              PC <= IR[4:0]
//   jmp                  jump taken (qualifies pc_load)
//   halt                 CPU halted
//   memIns_en            instruction memory read enable
//   memDa_en             data memory enable
//   memDa_we             data memory write enable (only with memDa_en)
//   accumulator_load     accumulator captures ALU result
//   accumulator_control  ALU operation select
//   cycle_count          cycles spent executing
//   instr_count          retired instructions
//
// Modports
//   master  sequencer side: drives the control bundle and counters
//   slave   datapath side: drives opcode and acc_zero
// -----------------------------------------------------------------------------
interface cpu_sequencer_if #(
  parameter int CNT_W   = 16,
  parameter int ALUOP_W = 3
);

  logic [2:0]         opcode;
  logic               acc_zero;

  logic               ir_load;
  logic               pc_en;
  logic               pc_load;
  logic               jmp;
  logic               halt;
  logic               memIns_en;
  logic               memDa_en;
  logic               memDa_we;
  logic               accumulator_load;
  logic [ALUOP_W-1:0] accumulator_control;

  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    input  opcode,
    input  acc_zero,
    output ir_load,
    output pc_en,
    output pc_load,
    output jmp,
    output halt,
    output memIns_en,
    output memDa_en,
    output memDa_we,
    output accumulator_load,
    output accumulator_control,
    output cycle_count,
    output instr_count
  );

  modport slave (
    output opcode,
    output acc_zero,
    input  ir_load,
    input  pc_en,
    input  pc_load,
    input  jmp,
    input  halt,
    input  memIns_en,
    input  memDa_en,
    input  memDa_we,
    input  accumulator_load,
    input  accumulator_control,
    input  cycle_count,
    input  instr_count
  );

endinterface : cpu_sequencer_if

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control FSM for the 8-bit accumulator CPU (opcode[7:5],
// addr[4:0]). Walks every instruction through FETCH, DECODE, EXEC and, for
// instructions that read data memory, MEMRD, driving the datapath control
// bundle. Also keeps saturating cycle and retired-instruction counters so the
// CPI of a program can be measured.
//
// Configuration macro
//   CPU_SEQ_STEP_EN  when defined, adds single-step ports step_mode/step and a
//                    WAIT state inserted in front of every FETCH while
//                    step_mode is 1. Undefined (default): free-running.
//
// Parameters
//   CNT_W    counter width (must match the interface instance)
//   ALUOP_W  ALU op width (must match the interface instance)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   step_mode  (CPU_SEQ_STEP_EN only) hold in WAIT before each fetch
//   step       (CPU_SEQ_STEP_EN only) release WAIT -> FETCH
//   bus        cpu_sequencer_if.master: opcode/acc_zero in, control and
//              counters out
//
// Outputs are decoded from the current state and opcode rather than
// registered: the opcode only becomes valid once EXEC has been entered, so an
// EXEC-phase output cannot be prepared a cycle early.
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int CNT_W   = 16,
  parameter int ALUOP_W = 3
) (
  input  logic clk,
  input  logic rst,
`ifdef CPU_SEQ_STEP_EN
  input  logic step_mode,
  input  logic step,
`endif
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEMRD,
    ST_HALTED
`ifdef CPU_SEQ_STEP_EN
    , ST_WAIT
`endif
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state;
  state_e             next_state;
  state_e             fetch_next;
  opcode_e            op;

  logic               ir_load;
  logic               pc_en;
  logic               pc_load;
  logic               jmp;
  logic               halt;
  logic               mem_ins_en;
  logic               mem_da_en;
  logic               mem_da_we;
  logic               acc_load;
  logic [ALUOP_W-1:0] acc_ctrl;

  // Set on the last phase of an instruction; the edge leaving it retires it.
  logic               last_phase;
  // Set in every state whose cycles count toward CPI.
  logic               active;

  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   instr_cnt;

  assign op = opcode_e'(bus.opcode);

  // Every entry into FETCH goes through here so single-step mode can divert
  // it into WAIT.
`ifdef CPU_SEQ_STEP_EN
  assign fetch_next = step_mode ? ST_WAIT : ST_FETCH;
`else
  assign fetch_next = ST_FETCH;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first; a path through
    // the case that skipped an assignment would otherwise infer a latch.
    next_state = state;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    jmp        = 1'b0;
    halt       = 1'b0;
    mem_ins_en = 1'b0;
    mem_da_en  = 1'b0;
    mem_da_we  = 1'b0;
    acc_load   = 1'b0;
    acc_ctrl   = '0;
    last_phase = 1'b0;
    active     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        next_state = fetch_next;
      end

      // Instruction RAM is synchronous: data is available in DECODE.
      ST_FETCH: begin
        active     = 1'b1;
        mem_ins_en = 1'b1;
        next_state = ST_DECODE;
      end

      ST_DECODE: begin
        active     = 1'b1;
        ir_load    = 1'b1;
        pc_en      = 1'b1;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        active     = 1'b1;
        last_phase = 1'b1;
        next_state = fetch_next;
        unique case (op)
          OP_HLT: begin
            halt       = 1'b1;
            next_state = ST_HALTED;
          end
          // Skip the next instruction by bumping PC a second time.
          OP_SKZ: pc_en = bus.acc_zero;
          OP_JMP: begin
            pc_load = 1'b1;
            jmp     = 1'b1;
          end
          OP_STO: begin
            mem_da_en = 1'b1;
            mem_da_we = 1'b1;
          end
          // ADD/AND/XOR/LDA: data RAM read now, result lands in MEMRD.
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            mem_da_en  = 1'b1;
            last_phase = 1'b0;
            next_state = ST_MEMRD;
          end
        endcase
      end

      ST_MEMRD: begin
        active     = 1'b1;
        last_phase = 1'b1;
        acc_load   = 1'b1;
        acc_ctrl   = ALUOP_W'(bus.opcode);
        next_state = fetch_next;
      end

      ST_HALTED: begin
        halt = 1'b1;
      end

`ifdef CPU_SEQ_STEP_EN
      // Counters hold here; step_mode dropping releases the wait as well.
      ST_WAIT: begin
        if (step || !step_mode) next_state = ST_FETCH;
      end
`endif

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register here sees pre-edge values of the others.
      state <= next_state;
      if (active && (cycle_cnt != CNT_MAX)) cycle_cnt <= cycle_cnt + 1'b1;
      if (last_phase && (instr_cnt != CNT_MAX)) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign bus.ir_load             = ir_load;
  assign bus.pc_en               = pc_en;
  assign bus.pc_load             = pc_load;
  assign bus.jmp                 = jmp;
  assign bus.halt                = halt;
  assign bus.memIns_en           = mem_ins_en;
  assign bus.memDa_en            = mem_da_en;
  assign bus.memDa_we            = mem_da_we;
  assign bus.accumulator_load    = acc_load;
  assign bus.accumulator_control = acc_ctrl;
  assign bus.cycle_count         = cycle_cnt;
  assign bus.instr_count         = instr_cnt;

endmodule : cpu_sequencer

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Closes the loop around cpu_sequencer with a small behavioural datapath
// (PC, IR, instruction/data RAM, accumulator) and compares every cycle
// against an expected trace generated from an instruction-level program
// interpreter. A second instance with CNT_W=4 runs a JMP-to-self loop to
// exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic       pc_load;
    logic       jmp;
    logic       halt;
    logic       mem_ins_en;
    logic       mem_da_en;
    logic       mem_da_we;
    logic       acc_load;
    logic [2:0] acc_ctrl;
  } ctl_t;

  typedef struct {
    ctl_t ctl;
    int   cyc;
    int   ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  cpu_sequencer_if #(.CNT_W(16), .ALUOP_W(3)) bus ();
  cpu_sequencer #(.CNT_W(16), .ALUOP_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  cpu_sequencer_if #(.CNT_W(4), .ALUOP_W(3)) bus4 ();
  cpu_sequencer #(.CNT_W(4), .ALUOP_W(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Narrow instance permanently sees a JMP: an endless jump-to-self loop.
  assign bus4.opcode   = 3'd7;
  assign bus4.acc_zero = 1'b0;

  // ---------------------------------------------------------------------------
  // Behavioural datapath
  // ---------------------------------------------------------------------------
  logic [7:0]  imem      [32];
  logic [7:0]  dmem_init [32];
  logic [7:0]  dmem      [32];
  logic [4:0]  pc;
  logic [7:0]  imem_q, ir, dmem_q, acc;
  logic [31:0] fetched;

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] m);
    case (op)
      3'd2:    alu = a + m;
      3'd3:    alu = a & m;
      3'd4:    alu = a ^ m;
      3'd5:    alu = m;
      default: alu = a;
    endcase
  endfunction

  assign bus.opcode   = ir[7:5];
  assign bus.acc_zero = (acc == 8'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      imem_q  <= '0;
      ir      <= '0;
      dmem_q  <= '0;
      acc     <= '0;
      fetched <= '0;
      for (int i = 0; i < 32; i++) dmem[i] <= dmem_init[i];
    end else begin
      if (bus.memIns_en) begin
        imem_q      <= imem[pc];
        fetched[pc] <= 1'b1;
      end
      if (bus.ir_load) ir <= imem_q;
      if (bus.pc_load)     pc <= ir[4:0];
      else if (bus.pc_en)  pc <= pc + 5'd1;
      if (bus.memDa_en) begin
        if (bus.memDa_we) dmem[ir[4:0]] <= acc;
        else              dmem_q <= dmem[ir[4:0]];
      end
      if (bus.accumulator_load) acc <= alu(bus.accumulator_control, acc, dmem_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: instruction-level interpreter emitting one expected
  // entry per clock cycle after reset release.
  // ---------------------------------------------------------------------------
  exp_t trace[$];

  task automatic push(input ctl_t c, input int cyc, input int ins);
    exp_t e;
    e.ctl = c;
    e.cyc = cyc;
    e.ins = ins;
    trace.push_back(e);
  endtask

  task automatic build_trace(input int ncyc);
    logic [7:0] m [32];
    logic [7:0] a;
    logic [4:0] p;
    logic [7:0] instr;
    logic [2:0] op;
    logic [4:0] ad;
    int   act;
    int   retired;
    bit   halted;
    ctl_t c;
    trace.delete();
    for (int i = 0; i < 32; i++) m[i] = dmem_init[i];
    a = '0; p = '0; act = 0; retired = 0; halted = 1'b0;
    while (trace.size() < ncyc) begin
      if (halted) begin
        c = '0; c.halt = 1'b1;
        push(c, act, retired);
      end else begin
        instr = imem[p];
        op    = instr[7:5];
        ad    = instr[4:0];
        c = '0; c.mem_ins_en = 1'b1;
        push(c, act, retired); act++;
        c = '0; c.ir_load = 1'b1; c.pc_en = 1'b1;
        push(c, act, retired); act++;
        p = p + 5'd1;
        c = '0;
        case (op)
          3'd0: begin c.halt = 1'b1; halted = 1'b1; end
          3'd1: begin c.pc_en = (a == 8'd0); if (a == 8'd0) p = p + 5'd1; end
          3'd6: begin c.mem_da_en = 1'b1; c.mem_da_we = 1'b1; m[ad] = a; end
          3'd7: begin c.pc_load = 1'b1; c.jmp = 1'b1; p = ad; end
          default: c.mem_da_en = 1'b1;
        endcase
        push(c, act, retired); act++;
        if (op inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
          c = '0; c.acc_load = 1'b1; c.acc_ctrl = op;
          push(c, act, retired); act++;
          a = alu(op, a, m[ad]);
        end
        retired++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  function automatic ctl_t observe();
    observe = {bus.ir_load, bus.pc_en, bus.pc_load, bus.jmp, bus.halt,
               bus.memIns_en, bus.memDa_en, bus.memDa_we,
               bus.accumulator_load, bus.accumulator_control};
  endfunction

  task automatic check_entry(input exp_t e, input string tag, input int k);
    ctl_t obs;
    obs = observe();
    vectors++;
    assert (obs === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl cyc%0d: got %h want %h", tag, k + 1, obs, e.ctl);
    end
    vectors++;
    assert (bus.cycle_count === 16'(e.cyc)) else begin
      miscompares++;
      $error("FAIL %s cycle_count cyc%0d: got %0d want %0d", tag, k + 1,
             bus.cycle_count, e.cyc);
    end
    vectors++;
    assert (bus.instr_count === 16'(e.ins)) else begin
      miscompares++;
      $error("FAIL %s instr_count cyc%0d: got %0d want %0d", tag, k + 1,
             bus.instr_count, e.ins);
    end
    vectors++;
    assert ((bus.memDa_we & ~bus.memDa_en) === 1'b0) else begin
      miscompares++;
      $error("FAIL %s we_without_en cyc%0d: got 1 want 0", tag, k + 1);
    end
    vectors++;
    assert ((bus.pc_en & bus.pc_load) === 1'b0) else begin
      miscompares++;
      $error("FAIL %s pc_en_and_load cyc%0d: got 1 want 0", tag, k + 1);
    end
  endtask

  task automatic check_zero(input string tag);
    ctl_t obs;
    obs = observe();
    vectors++;
    assert (obs === ctl_t'('0)) else begin
      miscompares++;
      $error("FAIL %s ctl: got %h want 0", tag, obs);
    end
    vectors++;
    assert ({bus.cycle_count, bus.instr_count} === 32'd0) else begin
      miscompares++;
      $error("FAIL %s counters: got %0d/%0d want 0/0", tag,
             bus.cycle_count, bus.instr_count);
    end
  endtask

  // Asserts rst away from a clock edge, checks the asynchronous clear, holds
  // it across one edge and releases it on the following falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_zero({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    check_zero({tag, "_held"});
    rst = 1'b0;
  endtask

  task automatic run_check(input int ncyc, input string tag);
    build_trace(ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_entry(trace[k], tag, k);
    end
  endtask

  task automatic load_prog(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
    for (int i = 0; i < 32; i++) begin
      imem[i]      = 8'h00;
      dmem_init[i] = 8'h00;
    end
    imem[0] = p0;
    imem[1] = p1;
    imem[2] = p2;
    imem[3] = p3;
  endtask

  task automatic check_val(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] b;
    int         exp_c;
    int         exp_i;
    logic       exp_j;

    load_prog(8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    do_reset("reset");

    // HLT at mem[0]: halt from the 3rd edge, held for 10 more.
    load_prog(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset("rst_hlt");
    run_check(13, "hlt");
    check_val("hlt_cycles", int'(bus.cycle_count), 3);
    check_val("hlt_instrs", int'(bus.instr_count), 1);

    // JMP 2; mem[1] is a STO that must never be fetched; HLT at mem[2].
    load_prog(8'hE2, 8'hC1, 8'h00, 8'h00);
    do_reset("rst_jmp");
    run_check(10, "jmp");
    check_val("jmp_skips_mem1", int'(fetched[1]), 0);
    check_val("jmp_instrs", int'(bus.instr_count), 2);

    // SKZ with accumulator zero (reset value): skips mem[1].
    load_prog(8'h20, 8'hE1, 8'h00, 8'h00);
    do_reset("rst_skz1");
    run_check(9, "skz_zero");

    // SKZ with accumulator non-zero: no skip.
    load_prog(8'hA3, 8'h20, 8'h00, 8'h00);
    dmem_init[3] = 8'h5A;
    do_reset("rst_skz0");
    run_check(12, "skz_nonzero");

    // LDA 5, STO 10, HLT.
    load_prog(8'hA5, 8'hCA, 8'h00, 8'h00);
    dmem_init[5] = 8'h37;
    do_reset("rst_ldsto");
    run_check(14, "lda_sto");
    check_val("ldsto_cycles", int'(bus.cycle_count), 10);
    check_val("ldsto_instrs", int'(bus.instr_count), 3);
    check_val("ldsto_mem10", int'(dmem[10]), 'h37);

    // Reset while in MEMRD of the LDA, then a clean rerun.
    do_reset("rst_pre_memrd");
    run_check(4, "to_memrd");
    do_reset("rst_in_memrd");
    run_check(14, "after_memrd_rst");

    // Random programs, cut off at a random cycle by an asynchronous reset.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 32; i++) begin
        b = 8'($urandom);
        if (b[7:5] == 3'd0 && $urandom_range(3) != 0) b[7:5] = 3'd2;
        imem[i]      = b;
        dmem_init[i] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      end
      do_reset("rst_rand");
      run_check(20 + int'($urandom_range(60)), "rand");
    end

    // CNT_W=4 instance: JMP-to-self loop, both counters saturate at 15.
    do_reset("rst_sat");
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_c = (k - 1 > 15) ? 15 : k - 1;
      exp_i = ((k - 1) / 3 > 15) ? 15 : (k - 1) / 3;
      exp_j = ((k - 1) % 3 == 2);
      vectors++;
      assert (bus4.cycle_count === 4'(exp_c)) else begin
        miscompares++;
        $error("FAIL sat cycle_count cyc%0d: got %0d want %0d", k,
               bus4.cycle_count, exp_c);
      end
      vectors++;
      assert (bus4.instr_count === 4'(exp_i)) else begin
        miscompares++;
        $error("FAIL sat instr_count cyc%0d: got %0d want %0d", k,
               bus4.instr_count, exp_i);
      end
      vectors++;
      assert ({bus4.pc_load, bus4.jmp} === {exp_j, exp_j}) else begin
        miscompares++;
        $error("FAIL sat jmp cyc%0d: got %b%b want %b%b", k,
               bus4.pc_load, bus4.jmp, exp_j, exp_j);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cpu_sequencer
